// File: rtl/irrigation_pkg.sv
// Shared types and condition codes for the irrigation scheduler.
// The condition code is decoded from the controller state and the latched valve selection.
package irrigation_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPEN,
        ST_RUN,
        ST_COOLDOWN,
        ST_FAULT
    } state_e;

    localparam logic [1:0] COND_IDLE      = 2'b00;
    localparam logic [1:0] COND_SPRINKLER = 2'b01;
    localparam logic [1:0] COND_DRIP      = 2'b10;
    localparam logic [1:0] COND_FAULT     = 2'b11;

    // sel: 1 = drip, 0 = sprinkler
    function automatic logic [1:0] cond_for(input state_e st, input logic sel);
        logic [1:0] cond;
        cond = COND_IDLE;
        if (st == ST_FAULT)
            cond = COND_FAULT;
        else if (st == ST_OPEN || st == ST_RUN)
            cond = sel ? COND_DRIP : COND_SPRINKLER;
        return cond;
    endfunction

endpackage

// File: rtl/irrigation_scheduler_if.sv
// Sensor inputs and valve/status outputs of the irrigation scheduler.
// The controller side uses the slave modport; the environment drives through master.
interface irrigation_scheduler_if;

    logic       soil_dry_i;
    logic       temp_high_i;
    logic       tank_empty_i;
    logic       fault_clr_i;
    logic       sprinkler_en_o;
    logic       drip_en_o;
    logic       irrigation_status_o;
    logic [1:0] cond_o;
    logic       timeout_o;

    modport master (
        output soil_dry_i, temp_high_i, tank_empty_i, fault_clr_i,
        input  sprinkler_en_o, drip_en_o, irrigation_status_o, cond_o, timeout_o
    );

    modport slave (
        input  soil_dry_i, temp_high_i, tank_empty_i, fault_clr_i,
        output sprinkler_en_o, drip_en_o, irrigation_status_o, cond_o, timeout_o
    );

endinterface

// File: rtl/irrigation_scheduler_cycle_timer.sv
// 16-bit down-counter timing every state duration; reloaded on each state entry.
// o_done flags the last cycle of a loaded interval (count == 1); a zero load stays idle.
module cycle_timer (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    output logic        o_done
);

    logic [15:0] r_count;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (r_count != 16'd0)
            r_count <= r_count - 16'd1;  // saturates at zero, never wraps
    end

    assign o_done = (r_count == 16'd1);

endmodule

// File: rtl/irrigation_scheduler.sv
// Irrigation controller: IDLE -> OPEN (valve settle) -> RUN -> COOLDOWN, with a FAULT
// trap on an empty tank. All outputs are registered from the next state and selection.
module irrigation_scheduler
    import irrigation_pkg::*;
#(
    parameter int unsigned VALVE_DELAY_CYC = 4,
    parameter int unsigned MAX_RUN_CYC     = 1000,
    parameter int unsigned COOLDOWN_CYC    = 50
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    irrigation_scheduler_if.slave  irr
);

    state_e      r_state;
    state_e      w_next_state;
    logic        r_sel;
    logic        w_sel_next;
    logic        w_timeout_set;
    logic        w_start;
    logic        w_load;
    logic [15:0] w_load_val;
    logic        w_timer_done;
    logic        w_valve_on;

    logic        r_sprinkler_en;
    logic        r_drip_en;
    logic        r_status;
    logic [1:0]  r_cond;
    logic        r_timeout;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state  = r_state;
        w_sel_next    = r_sel;
        w_timeout_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!irr.tank_empty_i && irr.soil_dry_i) begin
                    w_next_state = ST_OPEN;
                    w_sel_next   = irr.temp_high_i;
                end
            end
            ST_OPEN: begin
                if (irr.tank_empty_i)
                    w_next_state = ST_FAULT;
                else if (w_timer_done)
                    w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (irr.tank_empty_i)
                    w_next_state = ST_FAULT;
                else if (!irr.soil_dry_i)
                    w_next_state = ST_COOLDOWN;
                else if (w_timer_done) begin
                    w_next_state  = ST_COOLDOWN;
                    w_timeout_set = 1'b1;
                end
            end
            ST_COOLDOWN: begin
                if (w_timer_done)
                    w_next_state = ST_IDLE;
            end
            ST_FAULT: begin
                if (irr.fault_clr_i && !irr.tank_empty_i)
                    w_next_state = ST_COOLDOWN;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load_val = '0;
        case (w_next_state)
            ST_OPEN:     w_load_val = 16'(VALVE_DELAY_CYC);
            ST_RUN:      w_load_val = 16'(MAX_RUN_CYC);
            ST_COOLDOWN: w_load_val = 16'(COOLDOWN_CYC);
            default:     w_load_val = '0;
        endcase
    end

    assign w_load     = (w_next_state != r_state);
    assign w_start    = (r_state == ST_IDLE) && (w_next_state == ST_OPEN);
    assign w_valve_on = (w_next_state == ST_OPEN) || (w_next_state == ST_RUN);

    cycle_timer u_timer (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_timer_done)
    );

    // NOTE: outputs decode the next state so they change on the same edge as r_state.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state        <= ST_IDLE;
            r_sel          <= 1'b0;
            r_sprinkler_en <= 1'b0;
            r_drip_en      <= 1'b0;
            r_status       <= 1'b0;
            r_cond         <= COND_IDLE;
            r_timeout      <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_sel          <= w_sel_next;
            r_sprinkler_en <= w_valve_on && !w_sel_next;
            r_drip_en      <= w_valve_on && w_sel_next;
            r_status       <= (w_next_state == ST_RUN);
            r_cond         <= cond_for(w_next_state, w_sel_next);
            if (w_timeout_set)
                r_timeout <= 1'b1;
            else if (w_start)
                r_timeout <= 1'b0;
        end
    end

    assign irr.sprinkler_en_o      = r_sprinkler_en;
    assign irr.drip_en_o           = r_drip_en;
    assign irr.irrigation_status_o = r_status;
    assign irr.cond_o              = r_cond;
    assign irr.timeout_o           = r_timeout;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Self-checking bench: directed timelines for the key scenarios plus randomized
// stimulus against a phase/elapsed-time reference model.
module tb_irrigation_scheduler;

    localparam int VALVE = 2;
    localparam int MAXR  = 8;
    localparam int COOL  = 3;

    localparam int P_IDLE  = 0;
    localparam int P_OPEN  = 1;
    localparam int P_RUN   = 2;
    localparam int P_COOL  = 3;
    localparam int P_FAULT = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    int   m_phase;
    int   m_age;
    bit   m_sel;
    bit   m_timeout;

    irrigation_scheduler_if irr ();

    irrigation_scheduler #(
        .VALVE_DELAY_CYC (VALVE),
        .MAX_RUN_CYC     (MAXR),
        .COOLDOWN_CYC    (COOL)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .irr     (irr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Packed view {sprinkler, drip, status, cond[1:0], timeout}
    function automatic logic [5:0] dut_out();
        return {irr.sprinkler_en_o, irr.drip_en_o, irr.irrigation_status_o,
                irr.cond_o, irr.timeout_o};
    endfunction

    task automatic model_go(input int phase);
        m_phase = phase;
        m_age   = 0;
    endtask

    // Reference: phase plus number of cycles already spent in it.
    task automatic model_edge();
        if (!rst_n) begin
            model_go(P_IDLE);
            m_sel     = 1'b0;
            m_timeout = 1'b0;
            return;
        end
        m_age++;
        case (m_phase)
            P_IDLE:
                if (!irr.tank_empty_i && irr.soil_dry_i) begin
                    model_go(P_OPEN);
                    m_sel     = irr.temp_high_i;
                    m_timeout = 1'b0;
                end
            P_OPEN:
                if (irr.tank_empty_i) model_go(P_FAULT);
                else if (m_age == VALVE) model_go(P_RUN);
            P_RUN:
                if (irr.tank_empty_i) model_go(P_FAULT);
                else if (!irr.soil_dry_i) model_go(P_COOL);
                else if (m_age == MAXR) begin
                    model_go(P_COOL);
                    m_timeout = 1'b1;
                end
            P_COOL:
                if (m_age == COOL) model_go(P_IDLE);
            default:
                if (irr.fault_clr_i && !irr.tank_empty_i) model_go(P_COOL);
        endcase
    endtask

    function automatic logic [5:0] model_out();
        logic       on;
        logic [1:0] cond;
        on   = (m_phase == P_OPEN) || (m_phase == P_RUN);
        cond = 2'b00;
        if (m_phase == P_FAULT) cond = 2'b11;
        else if (on) cond = m_sel ? 2'b10 : 2'b01;
        return {on && !m_sel, on && m_sel, m_phase == P_RUN, cond, m_timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_inputs(input logic soil, input logic temp, input logic tank, input logic clr);
        irr.soil_dry_i   = soil;
        irr.temp_high_i  = temp;
        irr.tank_empty_i = tank;
        irr.fault_clr_i  = clr;
    endtask

    task automatic settle();
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (15) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_inputs(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (dut_out() !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_state cyc=%0d got=%b exp=%b", i, dut_out(), 6'b0);
            end
        end
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (dut_out() !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle got=%b exp=%b", dut_out(), 6'b0);
        end
    endtask

    task automatic test_sprinkler_run();
        int n;
        logic spr, st;
        logic [5:0] exp;
        for (int c = 0; c < 10; c++) begin
            n = c + 1;
            set_inputs(c < 6, 1'b0, 1'b0, 1'b0);
            tick();
            spr = (n >= 1) && (n <= 6);
            st  = (n >= 3) && (n <= 6);
            exp = {spr, 1'b0, st, spr ? 2'b01 : 2'b00, 1'b0};
            n_checks++;
            if (dut_out() !== exp) begin
                n_fail++;
                $display("FAIL sprinkler_run cycle=%0d got=%b exp=%b", n, dut_out(), exp);
            end
        end
    endtask

    task automatic test_drip_timeout();
        int n;
        logic drip, st, to;
        logic [5:0] exp;
        for (int c = 0; c < 15; c++) begin
            n = c + 1;
            set_inputs(1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            drip = ((n >= 1) && (n <= 10)) || (n == 15);
            st   = (n >= 3) && (n <= 10);
            to   = (n >= 11) && (n <= 14);
            exp  = {1'b0, drip, st, drip ? 2'b10 : 2'b00, to};
            n_checks++;
            if (dut_out() !== exp) begin
                n_fail++;
                $display("FAIL drip_timeout cycle=%0d got=%b exp=%b", n, dut_out(), exp);
            end
        end
        settle();
    endtask

    task automatic test_tank_fault();
        int n;
        logic [5:0] exp;
        for (int c = 0; c < 15; c++) begin
            n = c + 1;
            case (c)
                6:       set_inputs(1'b0, 1'b0, 1'b1, 1'b0);
                7:       set_inputs(1'b0, 1'b0, 1'b1, 1'b1);
                8:       set_inputs(1'b0, 1'b0, 1'b1, 1'b0);
                9:       set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
                10:      set_inputs(1'b0, 1'b0, 1'b0, 1'b1);
                14:      set_inputs(1'b1, 1'b0, 1'b0, 1'b0);
                default: set_inputs(c < 6, 1'b0, 1'b0, 1'b0);
            endcase
            tick();
            if (n <= 2)       exp = 6'b100_01_0;
            else if (n <= 6)  exp = 6'b101_01_0;
            else if (n <= 10) exp = 6'b000_11_0;
            else if (n <= 14) exp = 6'b000_00_0;
            else              exp = 6'b100_01_0;
            n_checks++;
            if (dut_out() !== exp) begin
                n_fail++;
                $display("FAIL tank_fault cycle=%0d got=%b exp=%b", n, dut_out(), exp);
            end
        end
        settle();
    endtask

    task automatic test_tank_empty_idle();
        for (int c = 0; c < 12; c++) begin
            set_inputs(1'b1, 1'($urandom_range(1)), 1'b1, 1'($urandom_range(1)));
            tick();
            n_checks++;
            if (dut_out() !== 6'b0) begin
                n_fail++;
                $display("FAIL tank_empty_idle cycle=%0d got=%b exp=%b", c, dut_out(), 6'b0);
            end
        end
        settle();
    endtask

    task automatic test_reset_mid_run();
        for (int c = 0; c < 4; c++) begin
            set_inputs(1'b1, c[0], 1'b0, 1'b0);
            tick();
            n_checks++;
            if ({irr.sprinkler_en_o, irr.drip_en_o} !== 2'b10) begin
                n_fail++;
                $display("FAIL sel_hold cycle=%0d got=%b exp=%b", c + 1,
                         {irr.sprinkler_en_o, irr.drip_en_o}, 2'b10);
            end
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (dut_out() !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run got=%b exp=%b", dut_out(), 6'b0);
        end
        rst_n = 1'b1;
        set_inputs(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (dut_out() !== 6'b010_10_0) begin
            n_fail++;
            $display("FAIL first_sample_after_reset got=%b exp=%b", dut_out(), 6'b010_10_0);
        end
        settle();
    endtask

    task automatic test_random();
        logic [5:0] exp;
        int dry_pct;
        for (int i = 0; i < 800; i++) begin
            dry_pct = (i < 400) ? 92 : 65;
            set_inputs($urandom_range(99) < dry_pct, 1'($urandom_range(1)),
                       $urandom_range(99) < 6, $urandom_range(99) < 25);
            rst_n = ($urandom_range(299) != 0);
            tick();
            exp = model_out();
            n_checks++;
            if (dut_out() !== exp) begin
                n_fail++;
                $display("FAIL random_model iter=%0d got=%b exp=%b", i, dut_out(), exp);
            end
            n_checks++;
            if (irr.sprinkler_en_o && irr.drip_en_o) begin
                n_fail++;
                $display("FAIL valve_exclusive iter=%0d got=%b exp=not both high", i,
                         {irr.sprinkler_en_o, irr.drip_en_o});
            end
        end
        settle();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        m_phase   = P_IDLE;
        m_age     = 0;
        m_sel     = 1'b0;
        m_timeout = 1'b0;
        rst_n     = 1'b0;
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_sprinkler_run();
        test_drip_timeout();
        test_tank_fault();
        test_tank_empty_idle();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irrigation_scheduler.md
IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

Interface
REQ-001 The block SHALL expose parameter VALVE_DELAY_CYC, default 4: number of cycles a valve stays open before irrigation counts as active (range 1..2^16-1).
REQ-002 The block SHALL expose parameter MAX_RUN_CYC, default 1000: maximum number of cycles in RUN before a timeout (range 1..2^16-1).
REQ-003 The block SHALL expose parameter COOLDOWN_CYC, default 50: number of idle cycles forced after every run (range 1..2^16-1).
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n_i  in  1  reset, synchronous, active-low.
REQ-006 soil_dry_i  in  1  soil humidity below threshold; requests irrigation.
REQ-007 temp_high_i  in  1  high ambient temperature; selects drip instead of sprinkler at start.
REQ-008 tank_empty_i  in  1  reservoir empty; inhibits start and aborts an active run.
REQ-009 fault_clr_i  in  1  one-cycle operator acknowledge that leaves FAULT.
REQ-010 sprinkler_en_o  out  1  sprinkler valve enable.
REQ-011 drip_en_o  out  1  drip valve enable.
REQ-012 irrigation_status_o  out  1  water is flowing (RUN state only).
REQ-013 cond_o  out  2  condition code: 00 idle/cooldown, 01 sprinkler, 10 drip, 11 fault.
REQ-014 timeout_o  out  1  sticky flag: last run ended by MAX_RUN_CYC.

Function
REQ-015 The FSM SHALL have states IDLE, OPEN, RUN, COOLDOWN, FAULT; all outputs SHALL be registered, decoded from state and latched selection.
REQ-016 IDLE: if tank_empty_i=1, stay IDLE; else if soil_dry_i=1, latch sel=temp_high_i (1=drip, 0=sprinkler) and go to OPEN next cycle.
REQ-017 OPEN: selected enable high, other low, irrigation_status_o=0; lasts exactly VALVE_DELAY_CYC cycles, then RUN.
REQ-018 RUN: selected enable high, irrigation_status_o=1; go to COOLDOWN on the first cycle soil_dry_i=0.
REQ-019 RUN: if soil_dry_i is still 1 in the MAX_RUN_CYC-th RUN cycle, go to COOLDOWN and set timeout_o=1.
REQ-020 timeout_o SHALL clear on the next IDLE->OPEN transition or on reset.
REQ-021 tank_empty_i=1 in OPEN or RUN SHALL go to FAULT next cycle with both enables low; this has priority over soil_dry_i deassertion and timeout in the same cycle.
REQ-022 FAULT: enables low, irrigation_status_o=0, cond_o=11; exit to COOLDOWN only when fault_clr_i=1 and tank_empty_i=0 in the same cycle, else stay.
REQ-023 COOLDOWN: all enables low; lasts exactly COOLDOWN_CYC cycles regardless of inputs, then IDLE.
REQ-024 Selection SHALL NOT change during OPEN/RUN; temp_high_i changes there are ignored.
REQ-025 sprinkler_en_o and drip_en_o SHALL never be high simultaneously.
REQ-026 The cycle counter SHALL be 16 bits, reload on every state entry, and never wrap.
REQ-027 cond_o SHALL be 01 or 10 per sel during OPEN and RUN.

Reset
REQ-028 With rst_n_i=0 at a clock edge: state=IDLE, sel=0, counter=0, all outputs 0 (cond_o=00, timeout_o=0), from any state including mid-run.
REQ-029 The first soil_dry_i sample after reset SHALL be taken on the first edge with rst_n_i=1.

Structure
REQ-030 Package irrigation_pkg SHALL hold the state enum and the cond_o code constants (COND_IDLE, COND_SPRINKLER, COND_DRIP, COND_FAULT).
REQ-031 One sub-module, cycle_timer (load value, load strobe, done pulse, 16-bit), SHALL implement all three state durations.

Verification (VALVE_DELAY_CYC=2, MAX_RUN_CYC=8, COOLDOWN_CYC=3)
REQ-032 soil_dry_i=1, temp_high_i=0 at cycle 0, drop at cycle 6 -> sprinkler_en_o high cycles 1-6, irrigation_status_o high cycles 3-6, cond_o=01, then 3 cycles 00/off, back to IDLE.
REQ-033 soil_dry_i held 1, temp_high_i=1 -> drip_en_o high 10 cycles (2 OPEN + 8 RUN), timeout_o=1 from COOLDOWN entry, cleared at next start.
REQ-034 tank_empty_i=1 on 4th RUN cycle while soil_dry_i drops same cycle -> FAULT, cond_o=11, enables low; fault_clr_i with tank_empty_i=1 ignored; with tank_empty_i=0 -> COOLDOWN, then IDLE.
REQ-035 tank_empty_i=1 and soil_dry_i=1 in IDLE -> no enable ever asserted, cond_o stays 00.
REQ-036 rst_n_i=0 for one cycle mid-RUN -> next cycle all outputs 0, state IDLE; temp_high_i toggling during RUN never changes the active enable.
